// File: rtl/alu_int_ctrl.sv
// Vector ALU controller: streams cmd_len operands from memory and reduces them
// (ADD/MUL/ARGMAX/AVG), or divides two operands with a restoring divider (DIV).
module alu_int_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [LEN_WIDTH-1:0]  res_index,
    output logic                  res_error,
    output logic                  busy
);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_MUL    = 4'b0001;
    localparam logic [3:0] OP_DIV    = 4'b0010;
    localparam logic [3:0] OP_ARGMAX = 4'b0100;
    localparam logic [3:0] OP_AVG    = 4'b1000;

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] DCNT_INIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [LEN_WIDTH-1:0]  elem_q, elem_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [LEN_WIDTH-1:0]  best_q, best_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]         dcnt_q, dcnt_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [LEN_WIDTH-1:0]  index_q, index_d;
    logic                  error_q, error_d;

    logic                  accept;
    logic                  op_ok;
    logic [DATA_WIDTH-1:0] acc_upd;
    logic [LEN_WIDTH-1:0]  best_upd;
    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH:0]   rem_diff;
    logic [DATA_WIDTH-1:0] rem_nx;
    logic [DATA_WIDTH-1:0] quo_nx;

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign res_valid   = (state_q == S_DONE);
    assign mem_rd_en   = (state_q == S_FETCH);
    assign mem_rd_addr = addr_q;
    assign result      = result_q;
    assign res_index   = index_q;
    assign res_error   = error_q;

    always_comb begin
        accept = cmd_valid && (state_q == S_IDLE);
        op_ok  = (cmd_op == OP_ADD) || (cmd_op == OP_MUL) || (cmd_op == OP_DIV) ||
                 (cmd_op == OP_ARGMAX) || (cmd_op == OP_AVG);

        // Reduction of the element arriving this cycle into the accumulator
        acc_upd  = acc_q;
        best_upd = best_q;
        case (op_q)
            OP_ADD, OP_AVG: acc_upd = acc_q + mem_rd_data;
            OP_MUL:         acc_upd = acc_q * mem_rd_data;
            OP_ARGMAX: begin
                if ((elem_q == '0) || ($signed(mem_rd_data) > $signed(acc_q))) begin
                    acc_upd  = mem_rd_data;
                    best_upd = elem_q;
                end
            end
            OP_DIV: if (elem_q == '0) acc_upd = mem_rd_data;
            default: ;
        endcase

        // One restoring-division step; remainder needs one extra bit for the compare
        rem_sh   = {rem_q, quo_q[DATA_WIDTH-1]};
        rem_diff = rem_sh - {1'b0, dvs_q};
        if (rem_sh >= {1'b0, dvs_q}) begin
            rem_nx = rem_diff[DATA_WIDTH-1:0];
            quo_nx = {quo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[DATA_WIDTH-1:0];
            quo_nx = {quo_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        len_d    = len_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        rd_vld_d = (state_q == S_FETCH);
        elem_d   = elem_q;
        acc_d    = acc_q;
        best_d   = best_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        dcnt_d   = dcnt_q;
        result_d = result_q;
        index_d  = index_q;
        error_d  = error_q;

        if (rd_vld_q) begin
            acc_d  = acc_upd;
            best_d = best_upd;
            elem_d = elem_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = cmd_op;
                    len_d  = cmd_len;
                    elem_d = '0;
                    best_d = '0;
                    acc_d  = (cmd_op == OP_MUL) ? DATA_WIDTH'(1) : '0;
                    if (!op_ok || ((cmd_len == '0) && (cmd_op != OP_DIV))) begin
                        state_d  = S_DONE;
                        result_d = '0;
                        index_d  = '0;
                        error_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        addr_d  = cmd_base;
                        cnt_d   = (cmd_op == OP_DIV) ? LEN_WIDTH'(2) : cmd_len;
                    end
                end
            end
            S_FETCH: begin
                cnt_d = cnt_q - 1'b1;
                // Address stops on the last element so it holds once reads end
                if (cnt_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
                else                        addr_d  = addr_q + 1'b1;
            end
            S_DRAIN: begin
                index_d = '0;
                error_d = 1'b0;
                if (op_q == OP_DIV) begin
                    if (mem_rd_data == '0) begin
                        state_d  = S_DONE;
                        result_d = '1;
                        error_d  = 1'b1;
                    end else begin
                        state_d = S_DIVIDE;
                        quo_d   = acc_q;
                        dvs_d   = mem_rd_data;
                        rem_d   = '0;
                        dcnt_d  = DCNT_INIT;
                    end
                end else if (op_q == OP_AVG) begin
                    state_d = S_DIVIDE;
                    quo_d   = acc_upd;
                    dvs_d   = DATA_WIDTH'(len_q);
                    rem_d   = '0;
                    dcnt_d  = DCNT_INIT;
                end else begin
                    state_d  = S_DONE;
                    result_d = acc_upd;
                    if (op_q == OP_ARGMAX) index_d = best_upd;
                end
            end
            S_DIVIDE: begin
                quo_d  = quo_nx;
                rem_d  = rem_nx;
                dcnt_d = dcnt_q - 1'b1;
                if (dcnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = quo_nx;
                    index_d  = '0;
                    error_d  = 1'b0;
                end
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            rd_vld_q <= 1'b0;
            elem_q   <= '0;
            acc_q    <= '0;
            best_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            dcnt_q   <= '0;
            result_q <= '0;
            index_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rd_vld_q <= rd_vld_d;
            elem_q   <= elem_d;
            acc_q    <= acc_d;
            best_q   <= best_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            dcnt_q   <= dcnt_d;
            result_q <= result_d;
            index_q  <= index_d;
            error_q  <= error_d;
        end
    end

endmodule

// File: tb/tb_alu_int_ctrl.sv
// Directed and randomized commands against a plain-arithmetic reference model.
module tb_alu_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_base;
    logic [7:0]  cmd_len;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic [7:0]  res_index;
    logic        res_error;
    logic        busy;

    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;

    alu_int_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .res_valid(res_valid), .res_ready(res_ready), .result(result),
        .res_index(res_index), .res_error(res_error), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_model(input logic [3:0] op, input logic [7:0] base, input logic [7:0] len,
                             output logic [31:0] r, output logic [7:0] idx, output logic e,
                             output int lat, output int nrd);
        logic [7:0]  a;
        logic [31:0] v;
        logic [31:0] b;
        r = 0; idx = 0; e = 0; lat = 0; nrd = 0;
        if (!(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000}) ||
            (len == 0 && op != 4'b0010)) begin
            e = 1; lat = 1;
        end else if (op == 4'b0010) begin
            a = base + 8'd1;
            v = mem[base];
            b = mem[a];
            nrd = 2;
            if (b == 0) begin r = 32'hFFFF_FFFF; e = 1; lat = 4; end
            else begin r = v / b; lat = 36; end
        end else begin
            nrd = len;
            lat = len + 2;
            r = (op == 4'b0001) ? 32'd1 : 32'd0;
            for (int i = 0; i < len; i++) begin
                a = base + 8'(i);
                v = mem[a];
                case (op)
                    4'b0001: r = r * v;
                    4'b0100: if (i == 0 || $signed(v) > $signed(r)) begin r = v; idx = 8'(i); end
                    default: r = r + v;
                endcase
            end
            if (op == 4'b1000) begin r = r / {24'd0, len}; lat = lat + 32; end
        end
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [7:0] base, input logic [7:0] len,
                           input int hold, input string tag);
        logic [31:0] e_res;
        logic [7:0]  e_idx;
        logic        e_err;
        int          e_lat, e_nrd, cyc, nrd;
        logic [7:0]  ea;
        logic [31:0] r0;
        bit          done;
        ref_model(op, base, len, e_res, e_idx, e_err, e_lat, e_nrd);
        @(negedge clk);
        chk({tag, " cmd_ready idle"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1; cmd_op = op; cmd_base = base; cmd_len = len; res_ready = 0;
        @(posedge clk);
        cyc = 0; nrd = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            // Garbage commands while busy must have no effect
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = 4'($urandom); cmd_base = 8'($urandom); cmd_len = 8'($urandom);
            if (mem_rd_en) begin
                ea = base + 8'(nrd);
                chk({tag, " rd_addr"}, {24'd0, mem_rd_addr}, {24'd0, ea});
                nrd++;
            end
            if (res_valid) done = 1;
        end
        cmd_valid = 0;
        chk({tag, " completed"}, {31'd0, done}, 32'd1);
        chk({tag, " latency"}, cyc, e_lat);
        chk({tag, " reads"}, nrd, e_nrd);
        chk({tag, " result"}, result, e_res);
        chk({tag, " index"}, {24'd0, res_index}, {24'd0, e_idx});
        chk({tag, " error"}, {31'd0, res_error}, {31'd0, e_err});
        r0 = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold result"}, result, r0);
            chk({tag, " hold cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
            chk({tag, " hold res_valid"}, {31'd0, res_valid}, 32'd1);
        end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        chk({tag, " released"}, {30'd0, res_valid, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        logic [3:0]  rop;
        cmd_valid = 0; cmd_op = 0; cmd_base = 0; cmd_len = 0; res_ready = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst mem_rd_addr", {24'd0, mem_rd_addr}, 32'd0);
        chk("rst outputs", {res_valid, res_error, busy}, 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst res_index", {24'd0, res_index}, 32'd0);

        mem[8'h10] = 1; mem[8'h11] = 2; mem[8'h12] = 3; mem[8'h13] = 4;
        run_cmd(4'b0000, 8'h10, 8'd4, 0, "add4");
        chk("add4 value", result, 32'd10);

        mem[8'h20] = -3; mem[8'h21] = 7; mem[8'h22] = 2; mem[8'h23] = 7; mem[8'h24] = -9;
        run_cmd(4'b0100, 8'h20, 8'd5, 0, "argmax");
        chk("argmax value", {res_index, result[23:0]}, {8'd1, 24'd7});

        mem[8'h30] = 32'h10000; mem[8'h31] = 32'h10000;
        run_cmd(4'b0001, 8'h30, 8'd2, 0, "mul");
        mem[8'h40] = 10; mem[8'h41] = 11; mem[8'h42] = 13;
        run_cmd(4'b1000, 8'h40, 8'd3, 0, "avg");
        mem[8'h50] = 100; mem[8'h51] = 7;
        run_cmd(4'b0010, 8'h50, 8'd0, 0, "div");
        mem[8'h60] = 5; mem[8'h61] = 0;
        run_cmd(4'b0010, 8'h60, 8'd9, 0, "div0");
        run_cmd(4'b0000, 8'h10, 8'd0, 0, "add_len0");
        run_cmd(4'b0011, 8'h10, 8'd4, 0, "bad_op");
        run_cmd(4'b0000, 8'h10, 8'd4, 10, "hold10");
        run_cmd(4'b0000, 8'hFE, 8'd3, 0, "wrap");
        run_cmd(4'b0010, 8'hFF, 8'd1, 0, "div_wrap");

        // Reset in the middle of a division aborts it
        @(negedge clk);
        cmd_valid = 1; cmd_op = 4'b0010; cmd_base = 8'h50; cmd_len = 0;
        @(negedge clk);
        cmd_valid = 0;
        repeat (10) @(negedge clk);
        chk("abort busy before", {31'd0, busy}, 32'd1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort res_valid", {31'd0, res_valid}, 32'd0);
        repeat (40) begin
            @(negedge clk);
            if (res_valid) chk("abort stray result", {31'd0, res_valid}, 32'd0);
        end
        run_cmd(4'b0000, 8'h10, 8'd4, 0, "after_abort");

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 256; i++) begin
                v = $urandom;
                mem[i] = (n % 2 == 0) ? (32'(v[3:0]) - 32'd8) : v;
            end
            case ($urandom_range(0, 6))
                0: rop = 4'b0000;
                1: rop = 4'b0001;
                2: rop = 4'b0010;
                3: rop = 4'b0100;
                4: rop = 4'b1000;
                5: rop = 4'b0100;
                default: rop = 4'($urandom);
            endcase
            if (rop == 4'b0010 && $urandom_range(0, 3) == 0) mem[8'h81] = 0;
            run_cmd(rop, (rop == 4'b0010) ? 8'h80 : 8'($urandom), 8'($urandom_range(0, 9)),
                    $urandom_range(0, 3), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
